alu_writeback: RTL

Writeback/condition-code stage directly downstream of the LC-3b ALU. It accepts the ALU result and its zero/positive/negative flags, together with per-instruction control from decode, into a 2-entry in-order buffer with a valid/ready handshake. When each entry retires, it updates the architectural NZP condition-code register. It also resolves BR conditions against the CC state in program order and presents the result and register-file write control to the register file.

---
 rtl/alu_writeback_if.sv | 78 +++++++
 rtl/alu_writeback.sv | 123 ++++++++++++
 2 files changed

// File: rtl/alu_writeback_if.sv
// Handshake bundle between the LC-3b ALU, the writeback stage and the register file / fetch.
// The design side is the slave modport; the environment driving it is the master modport.
interface alu_writeback_if #(
    parameter int WIDTH = 16
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic             in_zero;
    logic             in_positive;
    logic             in_negative;
    logic [2:0]       in_dest;
    logic             in_wen;
    logic             in_setcc;
    logic             in_br;
    logic [2:0]       in_br_nzp;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [2:0]       out_dest;
    logic             out_wen;
    logic             out_taken;
    logic             cc_n;
    logic             cc_z;
    logic             cc_p;
    logic             cc_err;

    modport slave (
        input  flush,
        input  in_valid,
        output in_ready,
        input  in_result,
        input  in_zero,
        input  in_positive,
        input  in_negative,
        input  in_dest,
        input  in_wen,
        input  in_setcc,
        input  in_br,
        input  in_br_nzp,
        output out_valid,
        input  out_ready,
        output out_result,
        output out_dest,
        output out_wen,
        output out_taken,
        output cc_n,
        output cc_z,
        output cc_p,
        output cc_err
    );

    modport master (
        output flush,
        output in_valid,
        input  in_ready,
        output in_result,
        output in_zero,
        output in_positive,
        output in_negative,
        output in_dest,
        output in_wen,
        output in_setcc,
        output in_br,
        output in_br_nzp,
        input  out_valid,
        output out_ready,
        input  out_result,
        input  out_dest,
        input  out_wen,
        input  out_taken,
        input  cc_n,
        input  cc_z,
        input  cc_p,
        input  cc_err
    );
endinterface

// File: rtl/alu_writeback.sv
// LC-3b writeback / condition-code stage: 2-entry in-order buffer that retires ALU results,
// updates the NZP register on setcc pops and resolves branches against the architectural CC.
module alu_writeback #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    alu_writeback_if.slave   bus
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [2:0]       flags;   // {negative, zero, positive}
        logic [2:0]       dest;
        logic             wen;
        logic             setcc;
        logic             br;
        logic [2:0]       br_nzp;
    } entry_t;

    function automatic logic f_onehot3(input logic [2:0] v);
        return (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
    endfunction

    entry_t     r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;
    logic [2:0] r_cc;
    logic       r_cc_err;

    entry_t     w_in_entry;
    entry_t     w_head;
    logic       w_in_ready;
    logic       w_out_valid;
    logic       w_push;
    logic       w_pop;
    logic [1:0] w_count_nxt;
    logic       w_taken;

    // Handshake qualification and next occupancy; in_ready comes from the registered count only.
    always_comb begin
        w_in_ready  = (r_count != 2'd2);
        w_out_valid = (r_count != 2'd0);
        w_push      = bus.in_valid & w_in_ready;
        w_pop       = w_out_valid & bus.out_ready;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Pack the incoming ALU result and decode control into one buffer entry.
    always_comb begin
        w_in_entry        = '0;
        w_in_entry.result = bus.in_result;
        w_in_entry.flags  = {bus.in_negative, bus.in_zero, bus.in_positive};
        w_in_entry.dest   = bus.in_dest;
        w_in_entry.wen    = bus.in_wen;
        w_in_entry.setcc  = bus.in_setcc;
        w_in_entry.br     = bus.in_br;
        w_in_entry.br_nzp = bus.in_br_nzp;
    end

    // Head entry and branch resolution against the CC as it stands this cycle.
    always_comb begin
        w_head  = r_mem[r_rd_ptr];
        w_taken = 1'b0;
        if (w_out_valid && w_head.br) begin
            w_taken = |(w_head.br_nzp & r_cc);
        end else begin
            w_taken = 1'b0;
        end
    end

    // Buffer storage, pointers, occupancy and the architectural condition codes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_cc     <= 3'b010;
            r_cc_err <= 1'b0;
        end else if (bus.flush) begin
            // Flush drops the buffer only; CC and the sticky error survive.
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_in_entry;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
                if (w_head.setcc) begin
                    if (f_onehot3(w_head.flags)) begin
                        r_cc <= w_head.flags;
                    end else begin
                        r_cc_err <= 1'b1;
                    end
                end
            end
            r_count <= w_count_nxt;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_result = w_head.result;
    assign bus.out_dest   = w_head.dest;
    assign bus.out_wen    = w_head.wen & w_out_valid;
    assign bus.out_taken  = w_taken;
    assign bus.cc_n       = r_cc[2];
    assign bus.cc_z       = r_cc[1];
    assign bus.cc_p       = r_cc[0];
    assign bus.cc_err     = r_cc_err;

endmodule
